// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-queue slice.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_BUSY,
    WAIT_DONE
  } tx_q_state_t;

endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// Synchronous FIFO with a first-word-fall-through head; a push into a full
// FIFO is still accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointers are exactly AW bits so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of the UART transmitter: requests one frame at a time,
// pops on TX busy, and flags dropped writes and transmitters that never start.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int SIZE         = UART_DATA_W,
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SIZE-1:0]         wr_data,
  input  logic                    wr_en,
  output logic                    wr_full,
  output logic [$clog2(DEPTH):0]  wr_count,
  output logic [SIZE-1:0]         tx_data,
  output logic                    tx_rq,
  input  logic                    tx_busy,
  output logic                    overflow,
  output logic                    timeout_err,
  input  logic                    clr_err
);

  localparam int            TW         = $clog2(BUSY_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

  tx_q_state_t      state;
  tx_q_state_t      next_state;
  logic [TW-1:0]    timer;
  logic [SIZE-1:0]  head;
  logic             fifo_empty;
  logic             pop;
  logic             rq_d;
  logic             load_d;
  logic             timer_clr;
  logic             timer_inc;
  logic             timeout_hit;
  logic             wr_drop;

  sync_fifo #(
    .WIDTH (SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (wr_data),
    .head    (head),
    .full    (wr_full),
    .empty   (fifo_empty),
    .count   (wr_count)
  );

  assign wr_drop = wr_en && wr_full && !pop;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (!fifo_empty && !tx_busy) next_state = REQ;
      REQ:       next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)                  next_state = WAIT_DONE;
        else if (timer == TIMER_LAST) next_state = IDLE;
      end
      WAIT_DONE: if (!tx_busy) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // The head byte is latched on the way into REQ so it is stable for the whole request.
  always_comb begin
    rq_d        = (state == REQ);
    load_d      = (state == IDLE) && (next_state == REQ);
    pop         = (state == WAIT_BUSY) && tx_busy;
    timer_clr   = (state == REQ);
    timer_inc   = (state == WAIT_BUSY) && !tx_busy;
    timeout_hit = timer_inc && (timer == TIMER_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_rq       <= 1'b0;
      tx_data     <= '0;
      timer       <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_rq <= rq_d;
      if (load_d) tx_data <= head;
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + 1'b1;
      if (wr_drop)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (timeout_hit)  timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed and randomized bench for uart_tx_queue with a behavioural TX stub
// and a queue-based reference model.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int BT    = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       wr_full;
  logic [4:0] wr_count;
  logic [7:0] tx_data;
  logic       tx_rq;
  logic       tx_busy = 1'b0;
  logic       overflow;
  logic       timeout_err;
  logic       clr_err = 1'b0;

  uart_tx_queue #(.SIZE(8), .DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .wr_full     (wr_full),
    .wr_count    (wr_count),
    .tx_data     (tx_data),
    .tx_rq       (tx_rq),
    .tx_busy     (tx_busy),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model
  logic [7:0] mq[$];
  logic [7:0] rx_log[$];
  bit         pend = 0;
  int         age = 0;
  bit         exp_ovf = 0;
  bit         exp_to = 0;
  logic [7:0] rq_data = '0;
  bit         prev_rq = 0;
  bit         last_rq = 0;
  bit         popped_evt = 0;
  int         rq_n = 0;

  // TX stub: mode 0 = normal, 1 = never busy, 2 = held busy
  int         stub_mode = 0;
  int         fix_dly = 0;
  int         fix_len = 2;
  bit         st_start = 0;
  int         st_dly = 0;
  int         st_left = 0;
  logic [7:0] st_cap = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit pop_m, push_m, to_m;
    @(posedge clk);
    pop_m = 0;
    to_m  = 0;
    popped_evt = 0;
    if (reset) begin
      mq.delete();
      pend = 0; exp_ovf = 0; exp_to = 0; st_start = 0;
    end else begin
      if (pend) begin
        age++;
        if (tx_busy) begin
          pop_m = 1; pend = 0;
        end else if (age == BT) begin
          to_m = 1; pend = 0;
        end
      end
      push_m = wr_en && (mq.size() < DEPTH || pop_m);
      if (pop_m && mq.size() > 0) begin
        chk("pop_byte", st_cap, mq[0]);
        rx_log.push_back(st_cap);
        void'(mq.pop_front());
        popped_evt = 1;
      end
      if (push_m) mq.push_back(wr_data);
      if (wr_en && !push_m) exp_ovf = 1;
      else if (clr_err)     exp_ovf = 0;
      if (to_m)         exp_to = 1;
      else if (clr_err) exp_to = 0;
    end
    #1;
    chk("count", wr_count, mq.size());
    chk("full", wr_full, mq.size() == DEPTH);
    chk("overflow", overflow, exp_ovf);
    chk("timeout_err", timeout_err, exp_to);
    last_rq = tx_rq;
    if (tx_rq) begin
      rq_n++;
      chk("rq_width", prev_rq, 1'b0);
      chk("rq_busy_low", tx_busy, 1'b0);
      chk("rq_nonempty", mq.size() != 0, 1'b1);
      if (mq.size() != 0) chk("rq_head", tx_data, mq[0]);
      pend = 1; age = 0; rq_data = tx_data;
      if (stub_mode == 0) begin
        st_start = 1;
        st_dly = (fix_dly >= 0) ? fix_dly : $urandom_range(0, 3);
        st_cap = tx_data;
      end
    end else if (pend) begin
      chk("data_hold", tx_data, rq_data);
    end
    prev_rq = tx_rq;
    @(negedge clk);
    case (stub_mode)
      2: tx_busy = 1'b1;
      1: begin tx_busy = 1'b0; st_start = 0; end
      default: begin
        if (st_start) begin
          if (st_dly == 0) begin
            tx_busy = 1'b1;
            st_left = (fix_len > 0) ? fix_len : $urandom_range(1, 5);
            st_start = 0;
          end else st_dly--;
        end else if (tx_busy) begin
          if (st_left <= 1) tx_busy = 1'b0;
          else st_left--;
        end
      end
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b0; clr_err = 1'b0;
    step();
    reset = 1'b0;
    chk("rst_count", wr_count, 0);
    chk("rst_rq", tx_rq, 1'b0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_flags", {overflow, timeout_err}, 2'b00);
  endtask

  task automatic drain();
    int n = 0;
    wr_en = 1'b0;
    while ((mq.size() != 0 || pend || tx_busy) && n < 2000) begin
      step(); n++;
    end
    chk("drain_bound", n < 2000, 1'b1);
    repeat (2) step();
  endtask

  task automatic wait_rq(input int bound);
    int n = 0;
    last_rq = 0;
    while (!last_rq && n < bound) begin
      step(); n++;
    end
    chk("rq_bound", last_rq, 1'b1);
  endtask

  initial begin
    int n, base_rq, base_rx;
    logic [7:0] stall_byte;

    do_reset();
    repeat (3) step();

    // single byte latency
    fix_dly = 0; fix_len = 3;
    base_rx = rx_log.size();
    wr_data = 8'hA5; wr_en = 1'b1;
    step(); wr_en = 1'b0;
    chk("lat_e0", tx_rq, 1'b0);
    step(); chk("lat_e1", tx_rq, 1'b0);
    step(); chk("lat_e2", tx_rq, 1'b1);
    step(); chk("lat_e3", tx_rq, 1'b0);
    drain();
    chk("single_rx", rx_log[base_rx], 8'hA5);
    chk("single_count", wr_count, 0);

    // burst of three
    base_rq = rq_n; base_rx = rx_log.size();
    for (int i = 1; i <= 3; i++) begin
      wr_data = 8'(i); wr_en = 1'b1; step();
    end
    drain();
    chk("burst_rq", rq_n - base_rq, 3);
    chk("burst_rx0", rx_log[base_rx], 8'h01);
    chk("burst_rx1", rx_log[base_rx+1], 8'h02);
    chk("burst_rx2", rx_log[base_rx+2], 8'h03);

    // fill with TX held busy
    stub_mode = 2; step(); step();
    for (int i = 0; i < 17; i++) begin
      wr_data = 8'($urandom); wr_en = 1'b1; step();
      if (i == 15) chk("fill_full", wr_full, 1'b1);
    end
    wr_en = 1'b0; step();
    chk("fill_count", wr_count, 16);
    chk("fill_ovf", overflow, 1'b1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("clr_ovf", overflow, 1'b0);

    // push and pop in the same cycle while full
    stub_mode = 0; fix_dly = 0; fix_len = 2;
    wait_rq(20);
    wr_data = 8'h5C; wr_en = 1'b1; step(); wr_en = 1'b0;
    chk("pp_popped", popped_evt, 1'b1);
    chk("pp_count", wr_count, 16);
    chk("pp_ovf", overflow, 1'b0);
    drain();

    // stalled transmitter
    stub_mode = 1;
    stall_byte = 8'h3E; wr_data = stall_byte; wr_en = 1'b1; step(); wr_en = 1'b0;
    wait_rq(10);
    n = 0;
    while (!timeout_err && n < 40) begin
      step(); n++;
    end
    chk("to_cycles", n, BT);
    chk("to_count", wr_count, 1);
    wait_rq(10);
    chk("retry_byte", tx_data, stall_byte);
    clr_err = 1'b1; stub_mode = 0; step(); clr_err = 1'b0;
    drain();

    // reset while a frame is in WAIT_DONE
    fix_len = 30;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'hC0 + 8'(i); wr_en = 1'b1; step();
    end
    wr_en = 1'b0;
    n = 0;
    while (!popped_evt && n < 30) begin
      step(); n++;
    end
    chk("mid_popped", popped_evt, 1'b1);
    chk("mid_count", wr_count, 3);
    do_reset();
    base_rq = rq_n;
    repeat (40) step();
    chk("post_rst_rq", rq_n - base_rq, 0);
    drain();

    // randomized traffic
    fix_dly = -1; fix_len = 0;
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 100) stub_mode = 1;
      if (c % 150 == 125) stub_mode = 0;
      wr_en   = ($urandom_range(0, 9) < 4);
      wr_data = 8'($urandom);
      clr_err = ($urandom_range(0, 19) == 0);
      step();
    end
    wr_en = 1'b0; clr_err = 1'b0; stub_mode = 0;
    drain();
    chk("final_count", wr_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
